// File: rtl/long_latency_scoreboard_pkg.sv
// Shared constants and types for the long-latency write scoreboard.
// The hazard-cause encoding exists only to make stall reasons visible in waveforms.
package long_latency_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    HAZ_NONE    = 3'd0,
    HAZ_RAW_RS1 = 3'd1,
    HAZ_RAW_RS2 = 3'd2,
    HAZ_WAW     = 3'd3,
    HAZ_FULL    = 3'd4
  } haz_cause_e;

endpackage

// File: rtl/long_latency_scoreboard_sb_counter.sv
// One register's outstanding-write counter: simultaneous inc/dec cancel,
// decrement at zero reports underflow, increment at max saturates.
module long_latency_scoreboard_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic pending,
  output logic at_max,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next  = cnt;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (dec && !inc) begin
      if (cnt == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_next = cnt - CNT_ONE;
      end
    end
  end

  // A last outstanding write retiring this cycle is already visible through
  // the write-through regfile, so it no longer counts as pending.
  assign pending = (cnt != '0) && !(dec && (cnt == CNT_ONE));
  assign at_max  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

  a_no_inc_at_max: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && at_max));

endmodule

// File: rtl/long_latency_scoreboard.sv
// Tracks writes still owed by loads and the mul/div unit and stalls ID on
// RAW/WAW hazards against them or when a register's counter is full.
module long_latency_scoreboard
  import long_latency_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = long_latency_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = long_latency_scoreboard_pkg::ADDR_W,
  parameter int CNT_W    = long_latency_scoreboard_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_reg_write_en,
  input  logic                issue_long_lat,
  input  logic [ADDR_W-1:0]   issue_rd_addr,
  input  logic [ADDR_W-1:0]   id_rs1_addr,
  input  logic [ADDR_W-1:0]   id_rs2_addr,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [ADDR_W-1:0]   id_rd_addr,
  input  logic                id_reg_write_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd_addr,
  output logic                stall_id,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                err_underflow
);

  logic                issue_fire;
  logic                wb_fire;
  logic [NUM_REGS-1:0] pending_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:0] uf_vec;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                waw_haz;
  logic                full_haz;
  haz_cause_e          haz_cause;

  assign issue_fire = issue_valid && issue_reg_write_en && issue_long_lat &&
                      (issue_rd_addr != REG_ZERO);
  assign wb_fire    = wb_valid && (wb_rd_addr != REG_ZERO);

  // x0 is hardwired: never tracked, never busy, never pending.
  assign pending_vec[0] = 1'b0;
  assign full_vec[0]    = 1'b0;
  assign uf_vec[0]      = 1'b0;
  assign busy_mask[0]   = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    long_latency_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_fire && (issue_rd_addr == ADDR_W'(r))),
      .dec       (wb_fire && (wb_rd_addr == ADDR_W'(r))),
      .busy      (busy_mask[r]),
      .pending   (pending_vec[r]),
      .at_max    (full_vec[r]),
      .underflow (uf_vec[r])
    );
  end

  assign rs1_haz  = id_uses_rs1 && (id_rs1_addr != REG_ZERO) && pending_vec[id_rs1_addr];
  assign rs2_haz  = id_uses_rs2 && (id_rs2_addr != REG_ZERO) && pending_vec[id_rs2_addr];
  assign waw_haz  = id_reg_write_en && (id_rd_addr != REG_ZERO) && pending_vec[id_rd_addr];
  assign full_haz = id_reg_write_en && (id_rd_addr != REG_ZERO) && full_vec[id_rd_addr];

  // The stall is derived from the cause so the debug encoding cannot drift
  // away from the real stall condition.
  always_comb begin
    haz_cause = HAZ_NONE;
    if (rs1_haz) begin
      haz_cause = HAZ_RAW_RS1;
    end else if (rs2_haz) begin
      haz_cause = HAZ_RAW_RS2;
    end else if (waw_haz) begin
      haz_cause = HAZ_WAW;
    end else if (full_haz) begin
      haz_cause = HAZ_FULL;
    end
  end

  assign stall_id = (haz_cause != HAZ_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (|uf_vec) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Directed plus randomized bench for long_latency_scoreboard, checked against
// a per-register outstanding-write count model.
module tb_long_latency_scoreboard;

  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_reg_write_en;
  logic          issue_long_lat;
  logic [4:0]    issue_rd_addr;
  logic [4:0]    id_rs1_addr;
  logic [4:0]    id_rs2_addr;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [4:0]    id_rd_addr;
  logic          id_reg_write_en;
  logic          wb_valid;
  logic [4:0]    wb_rd_addr;
  logic          stall_id;
  logic [NR-1:0] busy_mask;
  logic          err_underflow;

  int   total = 0;
  int   bad   = 0;
  int   cnt_m[NR];
  bit   err_m;
  logic last_stall;

  always #5 clk = ~clk;

  long_latency_scoreboard dut (
    .clk                (clk),
    .rst                (rst),
    .issue_valid        (issue_valid),
    .issue_reg_write_en (issue_reg_write_en),
    .issue_long_lat     (issue_long_lat),
    .issue_rd_addr      (issue_rd_addr),
    .id_rs1_addr        (id_rs1_addr),
    .id_rs2_addr        (id_rs2_addr),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .id_rd_addr         (id_rd_addr),
    .id_reg_write_en    (id_reg_write_en),
    .wb_valid           (wb_valid),
    .wb_rd_addr         (wb_rd_addr),
    .stall_id           (stall_id),
    .busy_mask          (busy_mask),
    .err_underflow      (err_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A register is pending while writes are owed, unless the last one lands now.
  function automatic bit model_pending(int r, bit wbv, int wbrd);
    return (r != 0) && (cnt_m[r] > 0) && !(wbv && (wbrd == r) && (cnt_m[r] == 1));
  endfunction

  function automatic bit model_stall(bit u1, int rs1, bit u2, int rs2,
                                     bit idwe, int idrd, bit wbv, int wbrd);
    bit s;
    s = (u1 && model_pending(rs1, wbv, wbrd)) ||
        (u2 && model_pending(rs2, wbv, wbrd)) ||
        (idwe && model_pending(idrd, wbv, wbrd)) ||
        (idwe && (idrd != 0) && (cnt_m[idrd] == 3));
    return s;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < NR; i++) m[i] = (cnt_m[i] != 0);
    return m;
  endfunction

  task automatic applyStimulus(input bit iv, input bit iwe, input bit ill, input int ird,
                               input bit u1, input int rs1, input bit u2, input int rs2,
                               input bit idwe, input int idrd,
                               input bit wbv, input int wbrd, input bit r);
    bit inc;
    bit dec;
    @(negedge clk);
    rst                = r;
    issue_valid        = iv;
    issue_reg_write_en = iwe;
    issue_long_lat     = ill;
    issue_rd_addr      = ird[4:0];
    id_uses_rs1        = u1;
    id_rs1_addr        = rs1[4:0];
    id_uses_rs2        = u2;
    id_rs2_addr        = rs2[4:0];
    id_reg_write_en    = idwe;
    id_rd_addr         = idrd[4:0];
    wb_valid           = wbv;
    wb_rd_addr         = wbrd[4:0];
    #1;
    last_stall = stall_id;
    checkOutput("stall_id", {31'b0, stall_id},
                {31'b0, model_stall(u1, rs1, u2, rs2, idwe, idrd, wbv, wbrd)});
    checkOutput("busy_mask", busy_mask, model_busy());
    checkOutput("err_underflow", {31'b0, err_underflow}, {31'b0, err_m});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NR; i++) cnt_m[i] = 0;
      err_m = 1'b0;
    end else begin
      for (int i = 1; i < NR; i++) begin
        inc = iv && iwe && ill && (ird == i);
        dec = wbv && (wbrd == i);
        if (inc && !dec) begin
          if (cnt_m[i] < 3) cnt_m[i]++;
        end else if (dec && !inc) begin
          if (cnt_m[i] == 0) err_m = 1'b1;
          else cnt_m[i]--;
        end
      end
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueLong(input int rd);
    applyStimulus(1, 1, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit u1, u2, idwe, wbv, iv, ill, r;
    int rs1, rs2, idrd, wbrd, ird;

    rst = 1'b1;
    issue_valid = 0; issue_reg_write_en = 0; issue_long_lat = 0; issue_rd_addr = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd_addr = 0; id_reg_write_en = 0; wb_valid = 0; wb_rd_addr = 0;
    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    checkOutput("reset_stall", {31'b0, last_stall}, 32'd0);
    checkOutput("reset_busy", busy_mask, 32'd0);

    // load to x5, consumer waits, same-cycle writeback releases it
    issueLong(5);
    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw5_c1", {31'b0, last_stall}, 32'd1);
    checkOutput("busy5_c1", {31'b0, busy_mask[5]}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw5_c2", {31'b0, last_stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("raw5_bypass", {31'b0, last_stall}, 32'd0);
    idle();
    checkOutput("busy5_c4", {31'b0, busy_mask[5]}, 32'd0);

    // two divides to x7, WAW stall until both return
    issueLong(7);
    issueLong(7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    checkOutput("waw7", {31'b0, last_stall}, 32'd1);
    checkOutput("busy7", {31'b0, busy_mask[7]}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    checkOutput("waw7_clear", {31'b0, last_stall}, 32'd0);
    idle();
    checkOutput("busy7_clear", {31'b0, busy_mask[7]}, 32'd0);

    // simultaneous issue and writeback to x9 leave the count at one
    issueLong(9);
    applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    idle();
    checkOutput("busy9_hold", {31'b0, busy_mask[9]}, 32'd1);
    checkOutput("no_uf_9", {31'b0, err_underflow}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    // stray writeback to x12, then an x0 destination that must be ignored
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    idle();
    checkOutput("uf_set", {31'b0, err_underflow}, 32'd1);
    issueLong(0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_stall", {31'b0, last_stall}, 32'd0);
    checkOutput("x0_busy", busy_mask, 32'd0);
    checkOutput("uf_sticky", {31'b0, err_underflow}, 32'd1);

    // fill x3 to max, then reset discards everything
    issueLong(3);
    issueLong(3);
    issueLong(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    checkOutput("full3", {31'b0, last_stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    checkOutput("rst_rs2_3", {31'b0, last_stall}, 32'd0);
    checkOutput("rst_busy", busy_mask, 32'd0);
    checkOutput("rst_uf", {31'b0, err_underflow}, 32'd0);

    // randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 600; n++) begin
      u1   = $urandom_range(0, 1);
      u2   = $urandom_range(0, 1);
      idwe = $urandom_range(0, 1);
      rs1  = $urandom_range(0, 7);
      rs2  = $urandom_range(0, 7);
      idrd = $urandom_range(0, 7);
      wbv  = ($urandom_range(0, 2) == 0);
      wbrd = $urandom_range(0, 7);
      ird  = $urandom_range(0, 7);
      ill  = ($urandom_range(0, 3) != 0);
      iv   = ($urandom_range(0, 1) == 1) &&
             !model_stall(u1, rs1, u2, rs2, idwe, idrd, wbv, wbrd);
      if (cnt_m[ird] == 3 && !(wbv && wbrd == ird)) ill = 1'b0;
      r    = ($urandom_range(0, 79) == 0);
      applyStimulus(iv, 1'b1, ill, ird, u1, rs1, u2, rs2, idwe, idrd, wbv, wbrd, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/long_latency_scoreboard.md
Name: long_latency_scoreboard

Overview:
- Tracks register writes still outstanding from long-latency producers: loads and the multi-cycle M-extension divide/multiply unit.
- Stalls the ID stage when a decoding instruction reads a register that one of these producers has not yet written back, or writes to one (WAW).
- Complements the EX/MEM and MEM/WB forwarding path. Forwarding covers single-cycle ALU results; this block covers results that no pipeline register holds yet.
- Sits between the decoder (read side), the ID/EX issue point (mark side) and the writeback arbiter (clear side).

Parameters:
- NUM_REGS, 32, architectural registers tracked (x0 never tracked).
- ADDR_W, 5, register address width.
- CNT_W, 2, per-register pending-write counter width; the maximum is 2^CNT_W-1 outstanding writes.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction moves ID->EX this cycle.
- issue_reg_write_en  in  1  issuing instruction writes rd.
- issue_long_lat  in  1  issuing instruction is a load/mul/div.
- issue_rd_addr  in  ADDR_W  rd of the issuing instruction.
- id_rs1_addr  in  ADDR_W  rs1 of the instruction in decode.
- id_rs2_addr  in  ADDR_W  rs2 of the instruction in decode.
- id_uses_rs1  in  1  decode instruction reads rs1.
- id_uses_rs2  in  1  decode instruction reads rs2.
- id_rd_addr  in  ADDR_W  rd of the instruction in decode.
- id_reg_write_en  in  1  decode instruction writes rd.
- wb_valid  in  1  a long-latency result is written to the regfile this cycle.
- wb_rd_addr  in  ADDR_W  destination of that writeback.
- stall_id  out  1  hold IF/ID and insert a bubble into ID/EX (combinational).
- busy_mask  out  NUM_REGS  registered: bit i = 1 while count[i] != 0.
- err_underflow  out  1  sticky: a writeback arrived for a register with count 0.

Behaviour:
- State: cnt[1..NUM_REGS-1], each CNT_W bits. cnt[0] is constant 0.
- Reset (synchronous, rst high at posedge): all cnt <= 0, busy_mask <= 0, err_underflow <= 0. rst dominates every other input in that cycle.
- inc(r) = issue_valid & issue_reg_write_en & issue_long_lat & (issue_rd_addr != 0) & (issue_rd_addr == r).
- dec(r) = wb_valid & (wb_rd_addr != 0) & (wb_rd_addr == r).
- Counter update per posedge: inc only -> +1; dec only -> -1; both -> unchanged.
- dec with cnt == 0 and no inc to the same register: cnt stays 0 and err_underflow <= 1 until reset.
- inc at max never occurs: stall_id prevents it. If it is forced anyway, cnt saturates. This case is verification-only and is flagged by an assertion.
- busy_mask[r] <= (next cnt[r] != 0). Latency is one cycle after issue/wb.
- pending(r) = (cnt[r] != 0) & !(dec(r) & cnt[r] == 1). The regfile is write-through, so a value written back this cycle is visible to ID this cycle.
- rs1_haz = id_uses_rs1 & (id_rs1_addr != 0) & pending(id_rs1_addr). rs2_haz is the same for rs2.
- waw_haz = id_reg_write_en & (id_rd_addr != 0) & pending(id_rd_addr). This preserves in-order writeback to the same register.
- full_haz = id_reg_write_en & (id_rd_addr != 0) & (cnt[id_rd_addr] == max).
- stall_id = rs1_haz | rs2_haz | waw_haz | full_haz. It is purely combinational from current state and inputs, with no dependence on issue_* signals.
- The pipeline guarantees issue_valid = 0 in any cycle where stall_id = 1. This block does not gate issue.
- Reset mid-operation: all pending state is discarded. In-flight writebacks after reset are the pipeline's responsibility to squash; a stray one sets err_underflow.
- x0: never incremented, decremented or reported pending.

Decomposition:
- Shared package: ADDR_W, NUM_REGS, REG_ZERO constant, and the hazard-cause encoding {NONE, RAW_RS1, RAW_RS2, WAW, FULL} (debug only).
- One natural sub-module: sb_counter (one CNT_W up/down counter with simultaneous inc/dec, underflow flag and saturation). It is instantiated NUM_REGS-1 times via generate.

Test Plan:
- Reset then idle -> stall_id = 0, busy_mask = 0, err_underflow = 0.
- Issue load rd=5 (cycle 0); ID reads rs1=5 in cycles 1-3; wb rd=5 in cycle 3 -> stall_id = 1 in cycles 1-2, 0 in cycle 3 (same-cycle bypass), busy_mask[5] = 0 from cycle 4.
- Issue div rd=7 twice (cycles 0 and 1), one wb rd=7 -> cnt[7] = 1, busy_mask[7] = 1, ID writing rd=7 stalls (WAW); a second wb clears it.
- Issue inc and wb dec to rd=9 in the same cycle with cnt[9] = 1 -> cnt[9] stays 1, no underflow.
- wb rd=12 with cnt[12] = 0 -> err_underflow = 1 and stays 1; issue rd=0 with long_lat -> busy_mask unchanged, no stall for rs1=0.
- Three outstanding issues to rd=3 (cnt = 3), then rst asserted -> next cycle all cnt = 0, stall_id = 0 for rs2=3.
